alu_cmd_issue: RTL and testbench

//   Command front-end directly upstream of the ALU.
//   - Accepts tagged {a, b, op} commands over a valid/ready port and queues them.
//   - Drives the ALU operand/op inputs, one command per cycle at most.
//   - Tracks each in-flight operation through the ALU's fixed latency, then captures {out, c}.
//   - Returns captured results with their tag over a valid/ready response port.
//   - Throttles itself so a response is never dropped.

---
 rtl/alu_issue_pkg.sv | 28 ++
 rtl/alu_sync_fifo.sv | 43 ++++
 rtl/alu_cmd_issue.sv | 144 ++++++++++++++
 tb/tb_alu_cmd_issue.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// Shared types for the ALU command front-end: command/response records and
// the default widths of the ALU they feed.
package alu_issue_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_OP_W   = 3;
    localparam int DEF_TAG_W  = 4;

    localparam logic [DEF_OP_W-1:0] OP_ADD = 3'd0;
    localparam logic [DEF_OP_W-1:0] OP_SUB = 3'd1;
    localparam logic [DEF_OP_W-1:0] OP_AND = 3'd2;
    localparam logic [DEF_OP_W-1:0] OP_OR  = 3'd3;
    localparam logic [DEF_OP_W-1:0] OP_XOR = 3'd4;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] a;
        logic [DEF_DATA_W-1:0] b;
        logic [DEF_OP_W-1:0]   op;
        logic [DEF_TAG_W-1:0]  tag;
    } cmd_t;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] out;
        logic                  c;
        logic [DEF_TAG_W-1:0]  tag;
    } rsp_t;

endpackage

// File: rtl/alu_sync_fifo.sv
// Generic synchronous FIFO. Pointers carry one extra bit so full and empty
// are told apart; the head reads as zero while the FIFO is empty.
module alu_sync_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  T                       din,
    output T                       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    T           mem [DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full)  wptr <= wptr + 1'b1;
            if (pop  && !empty) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wptr[AW-1:0]] <= din;
    end

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count = wptr - rptr;
    assign dout  = empty ? '0 : mem[rptr[AW-1:0]];

endmodule

// File: rtl/alu_cmd_issue.sv
// Command front-end for the ALU: queues tagged commands, issues one per cycle
// under a response credit limit, tracks ALU latency and returns tagged results.
module alu_cmd_issue
    import alu_issue_pkg::*;
#(
    // Width parameters must stay equal to the package struct widths.
    parameter int DATA_W    = DEF_DATA_W,
    parameter int OP_W      = DEF_OP_W,
    parameter int TAG_W     = DEF_TAG_W,
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4,
    parameter int ALU_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [TAG_W-1:0]  cmd_tag,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_c,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_out,
    output logic              rsp_c,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              busy
);

    localparam int IW = $clog2(ALU_LAT + 2);
    localparam int SW = $clog2(RSP_DEPTH + ALU_LAT + 2) + 1;

    cmd_t cmd_in, cmd_head;
    rsp_t rsp_in, rsp_head;
    logic cmd_full, cmd_empty, rsp_full, rsp_empty;
    logic [$clog2(CMD_DEPTH):0] cmd_count;
    logic [$clog2(RSP_DEPTH):0] rsp_count;
    logic [IW-1:0]              inflight_count;
    logic [SW-1:0]              credit_sum;
    logic                       issue_fire;
    logic                       cap_valid;
    logic [ALU_LAT:0]               vld_pipe;
    logic [ALU_LAT:0][TAG_W-1:0]    tag_pipe;

    assign cmd_ready = !cmd_full && !rst;

    always_comb begin
        cmd_in     = '0;
        cmd_in.a   = cmd_a;
        cmd_in.b   = cmd_b;
        cmd_in.op  = cmd_op;
        cmd_in.tag = cmd_tag;
    end

    alu_sync_fifo #(.T(cmd_t), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid && cmd_ready),
        .pop   (issue_fire),
        .din   (cmd_in),
        .dout  (cmd_head),
        .full  (cmd_full),
        .empty (cmd_empty),
        .count (cmd_count)
    );

    // Credits use registered counts only, so a same-cycle response pop never
    // opens a slot early and capture can never find the response FIFO full.
    assign credit_sum = SW'(rsp_count) + SW'(inflight_count);
    assign issue_fire = !cmd_empty && (credit_sum < SW'(RSP_DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
        end else if (issue_fire) begin
            alu_a  <= cmd_head.a;
            alu_b  <= cmd_head.b;
            alu_op <= cmd_head.op;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[ALU_LAT-1:0], issue_fire};
            tag_pipe <= {tag_pipe[ALU_LAT-1:0], cmd_head.tag};
        end
    end

    assign cap_valid = vld_pipe[ALU_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_count <= '0;
        end else begin
            case ({issue_fire, cap_valid})
                2'b10:   inflight_count <= inflight_count + 1'b1;
                2'b01:   inflight_count <= inflight_count - 1'b1;
                default: inflight_count <= inflight_count;
            endcase
        end
    end

    always_comb begin
        rsp_in     = '0;
        rsp_in.out = alu_out;
        rsp_in.c   = alu_c;
        rsp_in.tag = tag_pipe[ALU_LAT];
    end

    alu_sync_fifo #(.T(rsp_t), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cap_valid),
        .pop   (rsp_valid && rsp_ready),
        .din   (rsp_in),
        .dout  (rsp_head),
        .full  (rsp_full),
        .empty (rsp_empty),
        .count (rsp_count)
    );

    always_ff @(posedge clk) begin
        if (!rst && cap_valid) begin
            assert (!rsp_full) else $error("alu_cmd_issue: response fifo overflow");
        end
    end

    assign rsp_valid = !rsp_empty;
    assign rsp_out   = rsp_head.out;
    assign rsp_c     = rsp_head.c;
    assign rsp_tag   = rsp_head.tag;
    assign busy      = (cmd_count != '0) || (inflight_count != '0) || !rsp_empty;

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Directed and randomized checks of alu_cmd_issue driving a one-cycle
// registered ALU model.
module tb_alu_cmd_issue;
    import alu_issue_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready;
    logic [7:0] cmd_a, cmd_b;
    logic [2:0] cmd_op;
    logic [3:0] cmd_tag;
    logic [7:0] alu_a, alu_b, alu_out;
    logic [2:0] alu_op;
    logic       alu_c;
    logic       rsp_valid, rsp_ready, rsp_c, busy;
    logic [7:0] rsp_out;
    logic [3:0] rsp_tag;

    int vecs = 0, miscompares = 0;
    int acc_n = 0, rsp_n = 0;
    logic [12:0] exp_q[$];

    always #5 clk = ~clk;

    alu_cmd_issue dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_out(alu_out), .alu_c(alu_c),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_out(rsp_out), .rsp_c(rsp_c), .rsp_tag(rsp_tag),
        .busy(busy)
    );

    function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op);
        case (op)
            OP_ADD:  return {1'b0, a} + {1'b0, b};
            OP_SUB:  return {1'b0, a} - {1'b0, b};
            OP_AND:  return {1'b0, a & b};
            OP_OR:   return {1'b0, a | b};
            OP_XOR:  return {1'b0, a ^ b};
            default: return {1'b0, a};
        endcase
    endfunction

    // Downstream ALU: registered result one edge after its inputs change.
    always @(posedge clk) {alu_c, alu_out} <= alu_f(alu_a, alu_b, alu_op);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: transfers are sampled at the negedge, where inputs are stable.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                rsp_n++;
                chk("sb_pending", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) chk("sb_rsp", {rsp_tag, rsp_c, rsp_out}, exp_q.pop_front());
            end
            if (cmd_valid && cmd_ready) begin
                acc_n++;
                exp_q.push_back({cmd_tag, alu_f(cmd_a, cmd_b, cmd_op)});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input logic [3:0] tag);
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_tag   = tag;
    endtask

    initial begin
        int n, k, acc0, base;
        rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_tag = '0;
        rsp_ready = 1'b0;
        tick(); tick();
        chk("rst_ready", cmd_ready, 0);
        chk("rst_rsp", {rsp_valid, rsp_out, rsp_c, rsp_tag}, 0);
        chk("rst_alu", {alu_a, alu_b, alu_op}, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        tick();
        chk("rst_rel_ready", cmd_ready, 1);

        // 1: single ADD, response 3 edges after acceptance
        rsp_ready = 1'b1;
        send(8'h05, 8'h03, OP_ADD, 4'd2);
        chk("t1_ready", cmd_ready, 1);
        tick(); cmd_valid = 1'b0;
        chk("t1_e0", rsp_valid, 0);
        tick(); chk("t1_e1", rsp_valid, 0);
        tick(); chk("t1_e2", rsp_valid, 0);
        tick(); chk("t1_e3", rsp_valid, 1);
        chk("t1_out", rsp_out, 8'h08);
        chk("t1_c", rsp_c, 0);
        chk("t1_tag", rsp_tag, 2);
        tick();
        chk("t1_drain", {rsp_valid, busy}, 0);

        // 2: burst of 8, one response per cycle
        base = rsp_n;
        for (int i = 0; i < 8; i++) begin
            send(8'(i * 3), 8'(i + 10), OP_ADD, 4'(i));
            chk("t2_ready", cmd_ready, 1);
            tick();
        end
        cmd_valid = 1'b0;
        tick(); tick(); tick();
        chk("t2_last_valid", rsp_valid, 1);
        chk("t2_last_tag", rsp_tag, 7);
        chk("t2_last_out", rsp_out, 8'h26);
        chk("t2_count7", rsp_n - base, 7);
        tick();
        chk("t2_count8", rsp_n - base, 8);
        chk("t2_idle", busy, 0);

        // 3: backpressure with 10 commands
        rsp_ready = 1'b0;
        base = rsp_n; acc0 = acc_n; k = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            send(8'(k * 7), 8'(k + 1), OP_XOR, 4'(k + 3));
            tick();
            k = acc_n - acc0;
        end
        chk("t3_accepted", k, 8);
        chk("t3_cmd_ready", cmd_ready, 0);
        chk("t3_rsp_valid", rsp_valid, 1);
        chk("t3_head_tag", rsp_tag, 3);
        chk("t3_last_issue", alu_a, 8'd21);
        chk("t3_busy", busy, 1);
        rsp_ready = 1'b1;
        n = 0;
        while ((acc_n - acc0 < 10 || rsp_n - base < 10) && n < 60) begin
            k = acc_n - acc0;
            if (k < 10) send(8'(k * 7), 8'(k + 1), OP_XOR, 4'(k + 3));
            else cmd_valid = 1'b0;
            tick();
            n++;
        end
        cmd_valid = 1'b0;
        chk("t3_all_rsp", rsp_n - base, 10);
        chk("t3_sb_empty", exp_q.size(), 0);

        // 4: carry out, response held while stalled
        rsp_ready = 1'b0;
        send(8'hFF, 8'h01, OP_ADD, 4'd9);
        tick(); cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 10) begin tick(); n++; end
        chk("t4_wait", rsp_valid, 1);
        chk("t4_out", rsp_out, 8'h00);
        chk("t4_c", rsp_c, 1);
        chk("t4_tag", rsp_tag, 9);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_hold", {rsp_valid, rsp_tag, rsp_c, rsp_out}, {1'b1, 4'd9, 1'b1, 8'h00});
        end
        rsp_ready = 1'b1;
        tick();
        chk("t4_pop", rsp_valid, 0);

        // 5: reset with work queued, in flight and pending
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(8'(i), 8'(i), OP_ADD, 4'(i + 1));
            tick();
        end
        cmd_valid = 1'b0;
        chk("t5_busy_pre", {busy, rsp_valid}, 2'b11);
        rst = 1'b1;
        #1;
        chk("t5_rst_ctl", {cmd_ready, rsp_valid, busy}, 0);
        chk("t5_rst_alu", {alu_a, alu_b, alu_op}, 0);
        chk("t5_rst_rsp", {rsp_out, rsp_c, rsp_tag}, 0);
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("t5_rel", {cmd_ready, rsp_valid, busy}, 3'b100);
        base = rsp_n;
        rsp_ready = 1'b1;
        send(8'h40, 8'h22, OP_SUB, 4'hC);
        tick(); cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 10) begin tick(); n++; end
        chk("t5_new_rsp", {rsp_valid, rsp_tag, rsp_c, rsp_out}, {1'b1, 4'hC, 1'b0, 8'h1E});
        tick(); tick(); tick();
        chk("t5_no_stale", rsp_n - base, 1);
        chk("t5_idle", busy, 0);

        // 6: random traffic, 1000 commands
        acc0 = acc_n; base = rsp_n; n = 0;
        while (acc_n - acc0 < 1000 && n < 20000) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_a     = 8'($urandom);
            cmd_b     = 8'($urandom);
            cmd_op    = 3'($urandom_range(0, 7));
            cmd_tag   = 4'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
            n++;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        n = 0;
        while (rsp_n - base < 1000 && n < 100) begin tick(); n++; end
        chk("t6_accepted", acc_n - acc0, 1000);
        chk("t6_returned", rsp_n - base, 1000);
        chk("t6_sb_empty", exp_q.size(), 0);
        chk("t6_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
